// File: rtl/palindrome_tx.sv
// Serial palindrome frame transmitter: sends a captured half-word MSB-first,
// then its mirror, one bit per clock with sof/eof framing.
module palindrome_tx #(
  parameter int HALF_W = 4,
  parameter int ODD    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [HALF_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              sof,
  output logic              eof,
  output logic              busy
);

  localparam int L  = 2 * HALF_W - ODD;
  localparam int CW = $clog2(2 * HALF_W);
  localparam int SW = $clog2(HALF_W);
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

  state_t            state_q;
  logic [HALF_W-1:0] data_q;
  logic [CW-1:0]     idx_q;
  logic              dout_q;
  logic              dout_valid_q;
  logic              sof_q;
  logic              eof_q;

  logic [CW-1:0]     nxt_idx;
  logic [SW-1:0]     sel;
  logic              nxt_bit;
  logic              last;
  logic              accept;

  always_comb begin
    nxt_idx = idx_q + CW'(1);
    // Mirror half re-reads the captured word upward; ODD skips the centre bit.
    if (int'(nxt_idx) < HALF_W) sel = SW'(HALF_W - 1 - int'(nxt_idx));
    else                        sel = SW'(int'(nxt_idx) - HALF_W + ODD);
    nxt_bit   = data_q[sel];
    last      = dout_valid_q && (idx_q == LAST);
    din_ready = (state_q == IDLE) || last;
    accept    = din_valid && din_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      data_q       <= '0;
      idx_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
    end else if (accept) begin
      state_q      <= FWD;
      data_q       <= din;
      idx_q        <= '0;
      dout_q       <= din[HALF_W-1];
      dout_valid_q <= 1'b1;
      sof_q        <= 1'b1;
      eof_q        <= 1'b0;
    end else if (last || state_q == IDLE) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
    end else begin
      state_q      <= (int'(nxt_idx) < HALF_W) ? FWD : REV;
      idx_q        <= nxt_idx;
      dout_q       <= nxt_bit;
      dout_valid_q <= 1'b1;
      sof_q        <= 1'b0;
      eof_q        <= (nxt_idx == LAST);
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sof        = sof_q;
  assign eof        = eof_q;
  assign busy       = dout_valid_q;

endmodule
